// File: rtl/fb_pkg.sv
// Shared mode codes, prefetch FSM encoding and default pixel width for the frame buffer.
package fb_pkg;

    localparam logic [7:0] MODE_IDLE = 8'h01;
    localparam logic [7:0] MODE_RECV = 8'h02;
    localparam logic [7:0] MODE_DISP = 8'h03;

    localparam int unsigned PIX_W_DEFAULT = 12;

    typedef enum logic [0:0] {
        StPfIdle,
        StPfRun
    } pf_state_e;

    // Any other mode code leaves the previous mode in force.
    function automatic logic is_mode(input logic [7:0] m);
        return (m == MODE_IDLE) || (m == MODE_RECV) || (m == MODE_DISP);
    endfunction

endpackage

// File: rtl/line_bank.sv
// Ping-pong pair of W-entry line buffers: the back bank is written, the front bank is read
// asynchronously, and swap_i exchanges their roles at the next clock.
module line_bank #(
    parameter int unsigned W     = 50,
    parameter int unsigned PIX_W = 12,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             swap_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [PIX_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [PIX_W-1:0] rd_data_o
);

    logic sel_q, sel_d;
    logic [PIX_W-1:0] mem0 [W];
    logic [PIX_W-1:0] mem1 [W];

    always_comb begin
        sel_d = swap_i ? ~sel_q : sel_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // sel_q = 0: front is mem0, back is mem1.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            if (sel_q) begin
                mem0[wr_idx_i] <= wr_data_i;
            end else begin
                mem1[wr_idx_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = sel_q ? mem1[rd_idx_i] : mem0[rd_idx_i];

endmodule

// File: rtl/spram_frame_buf.sv
// Frame-buffer controller: streams a W x H image into SPRAM, then prefetches rows into a
// ping-pong line buffer for VGA. Optional FB_TEST_PATTERN_EN shows colour bars with no image.
module spram_frame_buf
    import fb_pkg::*;
#(
    parameter int unsigned W        = 50,
    parameter int unsigned H        = 40,
    parameter int unsigned PIX_W    = PIX_W_DEFAULT,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned STARTCOL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        state,
    input  logic              rx_valid,
    input  logic [PIX_W-1:0]  rx_data,
    input  logic              display_valid,
    input  logic [9:0]        x_addr,
    input  logic              line_req,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              image_receiving,
    output logic              image_complete,
    output logic              prefetch_busy,
    output logic              line_overrun,
    output logic [7:0]        cur_row,
    output logic [ADDR_W-1:0] spram_addr,
    output logic [PIX_W-1:0]  spram_wr_data,
    output logic              spram_wre,
    output logic              spram_ce,
    input  logic [PIX_W-1:0]  spram_rd_data
);

    localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(W * H - 1);

    logic [7:0]        mode_q, mode_d, eff_mode;
    logic              entering;
    pf_state_e         pf_state_q, pf_state_d;
    logic [CNT_W-1:0]  pf_cnt_q, pf_cnt_d;
    logic [ADDR_W-1:0] pf_base_q, pf_base_d;
    logic [7:0]        pf_row_q, pf_row_d, next_row;
    logic [7:0]        cur_row_q, cur_row_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              recv_q, recv_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  wdata_q, wdata_d;
    logic              wre_q, wre_d;
    logic              ce_q, ce_d;
    logic              swap, bank_we;
    logic [PIX_W-1:0]  front_pix;

    always_comb begin
        eff_mode = is_mode(state) ? state : mode_q;
        entering = (eff_mode != mode_q);
        next_row = (pf_row_q == 8'(H - 1)) ? 8'd0 : pf_row_q + 8'd1;

        mode_d     = eff_mode;
        pf_state_d = pf_state_q;
        pf_cnt_d   = pf_cnt_q;
        pf_base_d  = pf_base_q;
        pf_row_d   = pf_row_q;
        cur_row_d  = cur_row_q;
        pix_cnt_d  = pix_cnt_q;
        recv_d     = recv_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wre_d      = 1'b0;
        ce_d       = 1'b1;
        swap       = 1'b0;
        bank_we    = 1'b0;

        case (eff_mode)
            MODE_IDLE: begin
                recv_d     = 1'b0;
                done_d     = 1'b0;
                ovr_d      = 1'b0;
                pix_cnt_d  = '0;
                cur_row_d  = '0;
                pf_row_d   = '0;
                pf_cnt_d   = '0;
                pf_state_d = StPfIdle;
            end
            MODE_RECV: begin
                pf_state_d = StPfIdle;
                recv_d     = !done_q;
                if (rx_valid && !done_q) begin
                    addr_d  = pix_cnt_q;
                    wdata_d = rx_data;
                    wre_d   = 1'b1;
                    if (pix_cnt_q == LAST_PIX) begin
                        done_d    = 1'b1;
                        recv_d    = 1'b0;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                    end
                end
            end
            MODE_DISP: begin
                recv_d = 1'b0;
                // Run cycle j presents address base+j and captures the data of base+j-1.
                if (pf_state_q == StPfRun) begin
                    bank_we = (pf_cnt_q != '0);
                    if (pf_cnt_q == CNT_W'(W)) begin
                        pf_state_d = StPfIdle;
                    end else begin
                        pf_cnt_d = pf_cnt_q + CNT_W'(1);
                        if (pf_cnt_q < CNT_W'(W - 1)) begin
                            addr_d = pf_base_q + ADDR_W'(pf_cnt_q) + ADDR_W'(1);
                        end
                    end
                end
                if (entering) begin
                    if (done_q) begin
                        pf_row_d   = '0;
                        pf_base_d  = '0;
                        addr_d     = '0;
                        pf_cnt_d   = '0;
                        pf_state_d = StPfRun;
                    end
                end else if (line_req && done_q) begin
                    if (pf_state_q == StPfRun) begin
                        ovr_d = 1'b1;
                    end else begin
                        swap       = 1'b1;
                        cur_row_d  = pf_row_q;
                        pf_row_d   = next_row;
                        pf_base_d  = ADDR_W'(next_row) * ADDR_W'(W);
                        addr_d     = ADDR_W'(next_row) * ADDR_W'(W);
                        pf_cnt_d   = '0;
                        pf_state_d = StPfRun;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_IDLE;
            pf_state_q <= StPfIdle;
            pf_cnt_q   <= '0;
            pf_base_q  <= '0;
            pf_row_q   <= '0;
            cur_row_q  <= '0;
            pix_cnt_q  <= '0;
            recv_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wre_q      <= 1'b0;
            ce_q       <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            pf_state_q <= pf_state_d;
            pf_cnt_q   <= pf_cnt_d;
            pf_base_q  <= pf_base_d;
            pf_row_q   <= pf_row_d;
            cur_row_q  <= cur_row_d;
            pix_cnt_q  <= pix_cnt_d;
            recv_q     <= recv_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wre_q      <= wre_d;
            ce_q       <= ce_d;
        end
    end

    line_bank #(
        .W     (W),
        .PIX_W (PIX_W),
        .IDX_W (IDX_W)
    ) u_line_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .swap_i    (swap),
        .wr_en_i   (bank_we),
        .wr_idx_i  (IDX_W'(pf_cnt_q - CNT_W'(1))),
        .wr_data_i (spram_rd_data),
        .rd_idx_i  (IDX_W'(x_addr - 10'(STARTCOL))),
        .rd_data_o (front_pix)
    );

`ifdef FB_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (W / 8 > 0) ? W / 8 : 1;
    localparam int unsigned CH_W  = PIX_W / 3;
    logic [9:0] col;
    logic [9:0] bar_idx;
    logic [2:0] bar;
`endif

    always_comb begin
        pixel_data = '0;
`ifdef FB_TEST_PATTERN_EN
        col     = x_addr - 10'(STARTCOL);
        bar_idx = col / 10'(BAR_W);
        bar     = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
`endif
        if (display_valid && (x_addr >= 10'(STARTCOL)) &&
            ({1'b0, x_addr} < 11'(STARTCOL + W))) begin
            if ((eff_mode == MODE_DISP) && !done_q) begin
`ifdef FB_TEST_PATTERN_EN
                pixel_data[3*CH_W-1:0] = {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}};
`endif
            end else begin
                pixel_data = front_pix;
            end
        end
    end

    assign image_receiving = recv_q;
    assign image_complete  = done_q;
    assign prefetch_busy   = (pf_state_q == StPfRun);
    assign line_overrun    = ovr_q;
    assign cur_row         = cur_row_q;
    assign spram_addr      = addr_q;
    assign spram_wr_data   = wdata_q;
    assign spram_wre       = wre_q;
    assign spram_ce        = ce_q;

endmodule

// File: tb/tb_spram_frame_buf.sv
// Scoreboard bench for spram_frame_buf: SPRAM writes are checked by a monitor against a
// queue filled at stimulus time; displayed rows are checked against a flat image array.
module tb_spram_frame_buf;
    import fb_pkg::*;

    localparam int unsigned W        = 8;
    localparam int unsigned H        = 3;
    localparam int unsigned PIX_W    = 12;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned STARTCOL = 2;
    localparam int unsigned NPIX     = W * H;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        state;
    logic              rx_valid;
    logic [PIX_W-1:0]  rx_data;
    logic              display_valid;
    logic [9:0]        x_addr;
    logic              line_req;
    logic [PIX_W-1:0]  pixel_data;
    logic              image_receiving, image_complete, prefetch_busy, line_overrun;
    logic [7:0]        cur_row;
    logic [ADDR_W-1:0] spram_addr;
    logic [PIX_W-1:0]  spram_wr_data, spram_rd_data;
    logic              spram_wre, spram_ce;

    always #5 clk = ~clk;

    spram_frame_buf #(
        .W        (W),
        .H        (H),
        .PIX_W    (PIX_W),
        .ADDR_W   (ADDR_W),
        .STARTCOL (STARTCOL)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .state           (state),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .display_valid   (display_valid),
        .x_addr          (x_addr),
        .line_req        (line_req),
        .pixel_data      (pixel_data),
        .image_receiving (image_receiving),
        .image_complete  (image_complete),
        .prefetch_busy   (prefetch_busy),
        .line_overrun    (line_overrun),
        .cur_row         (cur_row),
        .spram_addr      (spram_addr),
        .spram_wr_data   (spram_wr_data),
        .spram_wre       (spram_wre),
        .spram_ce        (spram_ce),
        .spram_rd_data   (spram_rd_data)
    );

    // Single-port SRAM with one-cycle read latency.
    logic [PIX_W-1:0] sram [2**ADDR_W];
    always @(posedge clk) begin
        if (spram_ce) begin
            if (spram_wre) sram[spram_addr] <= spram_wr_data;
            else spram_rd_data <= sram[spram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+PIX_W-1:0] wr_q [$];
    logic [PIX_W-1:0]        img [NPIX];
    int                      exp_cnt = 0;
    bit                      exp_done = 1'b0;
    int                      exp_cur = 0;
    int                      exp_pf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (spram_wre) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL spram_write unexpected addr=%0h data=%0h required=none",
                         spram_addr, spram_wr_data);
            end else begin
                logic [ADDR_W+PIX_W-1:0] e;
                e = wr_q.pop_front();
                if ({spram_addr, spram_wr_data} !== e) begin
                    errors++;
                    $display("FAIL spram_write actual=%0h/%0h required=%0h/%0h",
                             spram_addr, spram_wr_data, e[ADDR_W+PIX_W-1:PIX_W], e[PIX_W-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_idle();
        exp_cnt  = 0;
        exp_done = 1'b0;
        exp_cur  = 0;
        exp_pf   = 0;
    endtask

    // Only called while the DUT is in receive mode.
    task automatic send_pix(input logic [PIX_W-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        if (!exp_done) begin
            wr_q.push_back({ADDR_W'(exp_cnt), d});
            img[exp_cnt] = d;
            exp_cnt++;
            if (exp_cnt == NPIX) begin
                exp_done = 1'b1;
                exp_cnt  = 0;
            end
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_line();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    task automatic accept_line();
        exp_cur = exp_pf;
        exp_pf  = (exp_pf + 1) % H;
    endtask

    // Called in the cycle right after a prefetch starts.
    task automatic wait_pf(input string name);
        int n = 0;
        check({name, " busy_rise"}, prefetch_busy, 1);
        while (prefetch_busy && n < 4 * W) begin
            tick();
            n++;
        end
        check({name, " busy_len"}, n, W + 1);
    endtask

    task automatic check_pixels(input string name);
        int k;
        display_valid = 1'b1;
        x_addr = 10'(STARTCOL); #1;
        check({name, " pix_first"}, pixel_data, img[exp_cur * W]);
        x_addr = 10'(STARTCOL + W - 1); #1;
        check({name, " pix_last"}, pixel_data, img[exp_cur * W + W - 1]);
        k = $urandom_range(0, W - 1);
        x_addr = 10'(STARTCOL + k); #1;
        check({name, " pix_rand"}, pixel_data, img[exp_cur * W + k]);
        x_addr = 10'(STARTCOL - 1); #1;
        check({name, " pix_left"}, pixel_data, 0);
        x_addr = 10'(STARTCOL + W); #1;
        check({name, " pix_right"}, pixel_data, 0);
        x_addr = 10'(STARTCOL + 1);
        display_valid = 1'b0; #1;
        check({name, " pix_blank"}, pixel_data, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " receiving"}, image_receiving, 0);
        check({name, " complete"}, image_complete, 0);
        check({name, " busy"}, prefetch_busy, 0);
        check({name, " overrun"}, line_overrun, 0);
        check({name, " cur_row"}, cur_row, 0);
        check({name, " addr"}, spram_addr, 0);
        check({name, " wdata"}, spram_wr_data, 0);
        check({name, " wre"}, spram_wre, 0);
        check({name, " ce"}, spram_ce, 1);
        check({name, " pixel"}, pixel_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0]       bar;
        logic [PIX_W-1:0] exp_pat;

        rst_n = 1'b0; state = MODE_IDLE; rx_valid = 1'b0; rx_data = '0;
        display_valid = 1'b0; x_addr = '0; line_req = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Aborted receive: IDLE discards progress, next receive restarts at address 0.
        state = MODE_RECV;
        tick();
        check("recv_entry", image_receiving, 1);
        for (int i = 0; i < 5; i++) send_pix(PIX_W'($urandom));
        state = MODE_IDLE;
        model_idle();
        tick();
        check("abort_receiving", image_receiving, 0);
        check("abort_complete", image_complete, 0);

        state = MODE_RECV;
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(0, 2) == 0) tick();
            send_pix(PIX_W'($urandom));
            if (i == 3) check("recv_mid", image_receiving, 1);
        end
        check("complete", image_complete, 1);
        check("recv_done", image_receiving, 0);
        send_pix(PIX_W'($urandom));
        tick();
        check("recv_queue_empty", wr_q.size(), 0);

        // Display: automatic row-0 prefetch, then a hold code keeps display mode.
        state = MODE_DISP;
        tick();
        wait_pf("entry");
        state = 8'hA5;
        for (int l = 0; l < 2 * H + 1; l++) begin
            repeat ($urandom_range(1, 4)) tick();
            pulse_line();
            accept_line();
            check("line cur_row", cur_row, exp_cur);
            check_pixels("line");
            wait_pf("line");
        end

        // Overrun: second request two cycles later is dropped.
        check("no_overrun", line_overrun, 0);
        pulse_line();
        accept_line();
        tick();
        pulse_line();
        check("overrun", line_overrun, 1);
        check("overrun cur_row", cur_row, exp_cur);
        n = 0;
        while (prefetch_busy && n < 4 * W) begin
            tick();
            n++;
        end
        check("overrun busy_end", prefetch_busy, 0);
        pulse_line();
        accept_line();
        check("after_overrun cur_row", cur_row, exp_cur);
        check_pixels("after_overrun");
        check("overrun sticky", line_overrun, 1);
        wait_pf("after_overrun");

        // IDLE in mid-prefetch aborts and clears.
        pulse_line();
        tick();
        state = MODE_IDLE;
        model_idle();
        tick();
        check("idle busy", prefetch_busy, 0);
        check("idle overrun", line_overrun, 0);
        check("idle complete", image_complete, 0);
        check("idle cur_row", cur_row, 0);

        // Reset in mid-prefetch.
        state = MODE_RECV;
        for (int i = 0; i < NPIX; i++) send_pix(PIX_W'($urandom));
        state = MODE_DISP;
        repeat (3) tick();
        check("pre_reset busy", prefetch_busy, 1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        model_idle();
        rst_n = 1'b1;
        repeat (2) tick();
        check("noimg busy", prefetch_busy, 0);
        bar = 3'd2;
`ifdef FB_TEST_PATTERN_EN
        exp_pat = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
        exp_pat = '0;
`endif
        display_valid = 1'b1;
        x_addr = 10'(STARTCOL) + 10'(bar);
        #1;
        check("noimg pixel", pixel_data, exp_pat);
        display_valid = 1'b0;
        pulse_line();
        tick();
        check("noimg line busy", prefetch_busy, 0);
        check("noimg line cur_row", cur_row, 0);
        check("noimg ce", spram_ce, 1);
        check("final queue_empty", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
